// File: rtl/uart_rx.sv
// UART receiver: synchronizes the serial line, recovers start/data/stop frames and emits one-cycle strobes.
// Define UART_RX_MAJORITY_EN to vote each bit as the 2-of-3 majority of the last three samples.
module uart_rx #(
   parameter int DATA_WIDTH  = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [15:0]           uart_cnt,
   input  logic                  uart_rxd,
   output logic [DATA_WIDTH-1:0] uart_data,
   output logic                  uart_flag,
   output logic                  uart_frame_err,
   output logic                  uart_busy
);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t                  state;
   logic [SYNC_STAGES-1:0]  sync_q;
   logic                    rxd_s;
   logic [15:0]             bps_cnt;
   logic [15:0]             cnt_lat;
   logic [3:0]              bit_cnt;
   logic [DATA_WIDTH-1:0]   shreg;
   logic [DATA_WIDTH-1:0]   shift_nxt;
   logic                    sample;
   logic                    vote;
   logic                    start_go;

   // Synchronizer: reset to the idle (high) line level so reset never looks like a start bit
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '1;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], uart_rxd};
      end
   end

   assign rxd_s  = sync_q[SYNC_STAGES-1];
   assign sample = (bps_cnt == 16'd0);

`ifdef UART_RX_MAJORITY_EN
   logic [1:0] hist;

   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

   always_ff @(posedge clk) begin
      if (bps_cnt == 16'd2) begin
         hist[1] <= rxd_s;
      end else if (bps_cnt == 16'd1) begin
         hist[0] <= rxd_s;
      end
   end

   assign vote = maj3(hist[1], hist[0], rxd_s);
`else
   assign vote = rxd_s;
`endif

   // A new frame may not begin in the cycle the previous frame's strobe is visible
   assign start_go = (state == IDLE) && !rxd_s && !uart_flag && !uart_frame_err;

   always_comb begin
      shift_nxt                 = shreg >> 1;
      shift_nxt[DATA_WIDTH-1]   = vote;
   end

   always_ff @(posedge clk) begin
      if (start_go) begin
         cnt_lat <= uart_cnt;
      end
      if (state == DATA && sample) begin
         shreg <= shift_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= IDLE;
         bps_cnt        <= 16'd0;
         bit_cnt        <= 4'd0;
         uart_data      <= '0;
         uart_flag      <= 1'b0;
         uart_frame_err <= 1'b0;
         uart_busy      <= 1'b0;
      end else begin
         uart_flag      <= 1'b0;
         uart_frame_err <= 1'b0;
         case (state)
            IDLE: begin
               uart_busy <= 1'b0;
               if (start_go) begin
                  state     <= START;
                  bps_cnt   <= (uart_cnt >> 1) - 16'd1;
                  uart_busy <= 1'b1;
               end
            end
            START: begin
               if (sample) begin
                  if (!vote) begin
                     state   <= DATA;
                     bps_cnt <= cnt_lat - 16'd1;
                     bit_cnt <= 4'd0;
                  end else begin
                     state     <= IDLE;
                     uart_busy <= 1'b0;
                  end
               end else begin
                  bps_cnt <= bps_cnt - 16'd1;
               end
            end
            DATA: begin
               if (sample) begin
                  bps_cnt <= cnt_lat - 16'd1;
                  if (bit_cnt == 4'(DATA_WIDTH - 1)) begin
                     state <= STOP;
                  end else begin
                     bit_cnt <= bit_cnt + 4'd1;
                  end
               end else begin
                  bps_cnt <= bps_cnt - 16'd1;
               end
            end
            STOP: begin
               // Leave at mid-stop-bit so a shortened stop bit still lets the next start be seen
               if (sample) begin
                  state <= IDLE;
                  if (vote) begin
                     uart_data <= shreg;
                     uart_flag <= 1'b1;
                  end else begin
                     uart_frame_err <= 1'b1;
                  end
               end else begin
                  bps_cnt <= bps_cnt - 16'd1;
               end
            end
            default: begin
               state     <= IDLE;
               uart_busy <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/uart_rx.md
# uart_rx

UART receiver for the loopback design. It oversamples the asynchronous serial line on the system clock and recovers 8N1-style frames (start bit, DATA_WIDTH data bits LSB first, one stop bit). Each received word is presented with a single-cycle strobe, in the same `uart_flag`/`uart_data` form the transmitter accepts. It sits directly upstream of `uart_tx` and shares the same runtime bit-period input `uart_cnt`.

## Interface
- `DATA_WIDTH`, default 8: data bits per frame (1–14).
- `SYNC_STAGES`, default 2: length of the input synchronizer flop chain (at least 2).

- `clk`, input, 1: system clock.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `uart_cnt`, input, 16: clocks per bit. Must be at least 8. Captured at frame start.
- `uart_rxd`, input, 1: asynchronous serial line; idles high.
- `uart_data`, output, DATA_WIDTH: last correctly framed word; holds its value between frames.
- `uart_flag`, output, 1: one-cycle pulse when `uart_data` is updated.
- `uart_frame_err`, output, 1: one-cycle pulse when the stop bit samples low.
- `uart_busy`, output, 1: high while a frame is in progress.

## Operation
- **Synchronizer:** `uart_rxd` passes through SYNC_STAGES flops, all reset to 1. Only the synchronized value `rxd_s` is used internally.
- **Counters:**
  - `bps_cnt` is a 16-bit down-counter; a bit is sampled when it reaches 0.
  - `bit_cnt` counts data bits.
  - `cnt_lat` holds `uart_cnt`, latched on entry to START. Changes to `uart_cnt` mid-frame are ignored.
- **States:**
  - IDLE: if `rxd_s`==0, go to START and load `bps_cnt` = (`uart_cnt`>>1) − 1.
  - START: at the sample point, a low vote goes to DATA and loads `bps_cnt` = `cnt_lat` − 1. A high vote is a false start: return to IDLE with no pulse.
  - DATA: at each sample point, shift the vote into the shift register MSB-first so the first bit received ends up as the LSB. Reload `bps_cnt` = `cnt_lat` − 1. After DATA_WIDTH bits, go to STOP.
  - STOP: at the sample point:
    - vote 1: `uart_data` ← shift register and pulse `uart_flag`.
    - vote 0: pulse `uart_frame_err` and leave `uart_data` unchanged.
    - Either way, return to IDLE immediately, at mid-stop-bit. This allows resynchronization on a stop bit shortened by up to half a bit period.
- **Busy:** `uart_busy`=1 in START, DATA and STOP, and during the cycle `uart_flag`/`uart_frame_err` is high. It is 0 in IDLE otherwise.
- **Flag and error:** `uart_flag` and `uart_frame_err` are never high in the same cycle.
- **Break condition:** a line held low gives a frame error, then immediately a new START. IDLE only restarts when it sees `rxd_s`==0.

## Timing
- **Reset values:** `uart_data`=0, `uart_flag`=0, `uart_frame_err`=0, `uart_busy`=0, state=IDLE, synchronizer=all 1.
- **Reference cycle:** T0 is the first cycle IDLE sees `rxd_s`==0. This is SYNC_STAGES clocks after the line falls.
- **Sample points** (C = `cnt_lat`):
  - start bit: T0 + (C>>1)
  - data bit k (k = 0 .. DATA_WIDTH−1): T0 + (C>>1) + (k+1)·C
  - stop bit: T0 + (C>>1) + (DATA_WIDTH+1)·C
- `uart_flag` or `uart_frame_err` is high in the cycle after the stop sample point.
- The earliest next T0 is the cycle after the pulse.
- **Reset mid-frame:** asynchronous return to IDLE. No pulse is emitted and `uart_data` is cleared to 0.

## Configuration
- **Macro:** `UART_RX_MAJORITY_EN`.
- **Defined:** the vote at each sample point is the 2-of-3 majority of `rxd_s` at `bps_cnt` = 2, 1 and 0. The values at counts 2 and 1 are captured in a 2-bit history register.
- **Undefined:** the vote is the single value of `rxd_s` at `bps_cnt`==0, and the history register is omitted.
- All state timing is identical in both builds.

## Test plan
- **Basic frame:** `uart_cnt`=434; send 0x55, then 0xA3 with a full stop bit. Expect exactly two `uart_flag` pulses, with `uart_data`=0x55 then 0xA3. The pulse must land at T0 + 217 + 9·434 + 1.
- **False start:** a low glitch of 100 clocks with `uart_cnt`=434. Expect no `uart_flag`, no `uart_frame_err`, and `uart_busy` dropping about 217 clocks after T0. `uart_data` is unchanged.
- **Frame error:** send 0x3C with the stop bit driven low. Expect one `uart_frame_err` pulse, no `uart_flag`, and `uart_data` still holding its previous value.
- **Loopback with `uart_tx`:** connect `uart_tx` to `uart_rxd` with `uart_cnt`=16 and send 0x00, 0xFF, 0x81 back-to-back (stop bit 15 clocks long). Expect all three bytes received in order with no errors.
- **Reset mid-frame:** assert `rst_n` low during data bit 4, then release. Expect all outputs at their reset values. A following 0x5A frame is received correctly.
- **Majority vote:** invert `uart_rxd` for exactly 1 clock around the sample point of bit 2 of 0x00, with `uart_cnt`=16. With `UART_RX_MAJORITY_EN` defined, expect `uart_data`=0x00. Without it, expect `uart_data`=0x04.
